// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display: FSM states and
// active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam int DIGITS = 4;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } sw_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// produce a blank digit.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch with a multiplexed 4-digit seven-segment driver.
// Define LEADING_BLANK_EN to blank the minutes-tens digit when it is zero.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       N_Clk1Hz,
    input  logic       N_Clk381Hz,
    input  logic       StartStop,
    input  logic       Clear,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic       Running
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    logic       clk1_prev_q, clk1_prev_d;
    logic       clk381_prev_q, clk381_prev_d;
    logic       ss_prev_q, ss_prev_d;
    sw_state_e  state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [1:0] idx_q, idx_d;
    logic       lit_q, lit_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       running_q, running_d;

    logic       tick1, tick381, ss_edge, at_max;
    logic [3:0] so_inc, st_inc, mo_inc, mt_inc;
    logic [3:0] digit_val;
    logic [6:0] dec_seg, sel_seg;

    assign tick1   = N_Clk1Hz & ~clk1_prev_q;
    assign tick381 = N_Clk381Hz & ~clk381_prev_q;
    assign ss_edge = StartStop & ~ss_prev_q;
    assign at_max  = (min_tens_q == MAX_TENS) && (min_ones_q == MAX_ONES) &&
                     (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

    always_comb begin
        so_inc = sec_ones_q + 4'd1;
        st_inc = sec_tens_q;
        mo_inc = min_ones_q;
        mt_inc = min_tens_q;
        if (sec_ones_q == 4'd9) begin
            so_inc = 4'd0;
            st_inc = sec_tens_q + 4'd1;
            if (sec_tens_q == 4'd5) begin
                st_inc = 4'd0;
                mo_inc = min_ones_q + 4'd1;
                if (min_ones_q == 4'd9) begin
                    mo_inc = 4'd0;
                    mt_inc = min_tens_q + 4'd1;
                end
            end
        end
    end

    // Clear overrides everything; a stop request coinciding with a tick
    // still lets the tick land first.
    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (Clear) begin
            state_d    = STOPPED;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            case (state_q)
                STOPPED: begin
                    if (ss_edge) state_d = RUNNING;
                end
                RUNNING: begin
                    if (tick1 && at_max) begin
                        state_d = DONE;
                    end else begin
                        if (tick1) begin
                            sec_ones_d = so_inc;
                            sec_tens_d = st_inc;
                            min_ones_d = mo_inc;
                            min_tens_d = mt_inc;
                        end
                        if (ss_edge) state_d = STOPPED;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = STOPPED;
            endcase
        end
    end

    always_comb begin
        clk1_prev_d   = N_Clk1Hz;
        clk381_prev_d = N_Clk381Hz;
        ss_prev_d     = StartStop;
        idx_d         = idx_q + 2'(tick381);
        lit_d         = lit_q | tick381;
    end

    always_comb begin
        digit_val = sec_ones_q;
        case (idx_q)
            2'd0: digit_val = sec_ones_q;
            2'd1: digit_val = sec_tens_q;
            2'd2: digit_val = min_ones_q;
            2'd3: digit_val = min_tens_q;
            default: digit_val = sec_ones_q;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_val),
        .seg (dec_seg)
    );

    always_comb begin
        sel_seg = dec_seg;
`ifdef LEADING_BLANK_EN
        if ((idx_q == 2'd3) && (min_tens_q == 4'd0)) sel_seg = SEG_BLANK;
`endif
        an_d      = 4'b1111;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b1;
        running_d = (state_q == RUNNING);
        // Display stays dark until the first refresh tick after reset.
        if (lit_q) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = sel_seg;
            dp_d  = (idx_q != 2'd2);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk1_prev_q   <= 1'b0;
            clk381_prev_q <= 1'b0;
            ss_prev_q     <= 1'b0;
            state_q       <= STOPPED;
            sec_ones_q    <= 4'd0;
            sec_tens_q    <= 4'd0;
            min_ones_q    <= 4'd0;
            min_tens_q    <= 4'd0;
            idx_q         <= 2'd0;
            lit_q         <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            running_q     <= 1'b0;
        end else begin
            clk1_prev_q   <= clk1_prev_d;
            clk381_prev_q <= clk381_prev_d;
            ss_prev_q     <= ss_prev_d;
            state_q       <= state_d;
            sec_ones_q    <= sec_ones_d;
            sec_tens_q    <= sec_tens_d;
            min_ones_q    <= min_ones_d;
            min_tens_q    <= min_tens_d;
            idx_q         <= idx_d;
            lit_q         <= lit_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            running_q     <= running_d;
        end
    end

    assign An      = an_q;
    assign Seg     = seg_q;
    assign Dp      = dp_q;
    assign Running = running_q;

endmodule
